exec_hazard_sched: RTL and testbench



---
 rtl/params_proc.sv | 10 +
 rtl/exec_hazard_sched_hazard_cmp.sv | 17 +
 rtl/exec_hazard_sched.sv | 103 ++++++++++
 tb/tb_exec_hazard_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/params_proc.sv
// params_proc: shared pipeline constants, opcodes and MDU latency defaults.
package params_proc;
  localparam int CTRL_WIDTH = 6;
  localparam int REG_ADDR_WIDTH = 4;
  localparam logic [5:0] OP_LW = 6'h03;
  localparam logic [5:0] OP_MUL = 6'h18;
  localparam logic [5:0] OP_DIV = 6'h1a;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;
endpackage

// File: rtl/exec_hazard_sched_hazard_cmp.sv
// hazard_cmp: flags a load-use hazard that forwarding cannot cover.
module hazard_cmp #(
  parameter int REG_ADDR_WIDTH = params_proc::REG_ADDR_WIDTH
) (
  input  logic                      valid_p23,
  input  logic                      valid_p34,
  input  logic                      load_p34,
  input  logic                      use_A,
  input  logic                      use_B,
  input  logic [REG_ADDR_WIDTH-1:0] A_addr,
  input  logic [REG_ADDR_WIDTH-1:0] B_addr,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_p34,
  output logic                      hz
);
  assign hz = valid_p23 & valid_p34 & load_p34 & (reg_addr_p34 != '0) &
              ((use_A & (A_addr == reg_addr_p34)) | (use_B & (B_addr == reg_addr_p34)));
endmodule

// File: rtl/exec_hazard_sched.sv
// exec_hazard_sched: stage-3 load-use stall and iterative MDU sequencer.
module exec_hazard_sched #(
  parameter int CTRL_WIDTH     = params_proc::CTRL_WIDTH,
  parameter int REG_ADDR_WIDTH = params_proc::REG_ADDR_WIDTH,
  parameter int MUL_LAT        = params_proc::MUL_LAT,
  parameter int DIV_LAT        = params_proc::DIV_LAT,
  parameter int LU_STALL       = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_p3,
  input  logic                      RST,
  input  logic                      valid_p23,
  input  logic [CTRL_WIDTH-1:0]     ctrl_p23,
  input  logic [REG_ADDR_WIDTH-1:0] A_addr,
  input  logic [REG_ADDR_WIDTH-1:0] B_addr,
  input  logic                      use_A,
  input  logic                      use_B,
  input  logic                      valid_p34,
  input  logic                      load_p34,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_p34,
  input  logic                      flush,
  output logic                      hold_p12,
  output logic                      bubble_p3,
  output logic                      done_p3,
  output logic                      mdu_start,
  output logic                      mdu_op,
  output logic                      mdu_abort,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, LSTALL = 2'd1, MDU = 2'd2} state_t;
  localparam int LMAX = (DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT) > LU_STALL ?
                        (DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT) : LU_STALL;
  localparam int CW = $clog2(LMAX + 1);
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_mdu_start;
  logic                  r_mdu_op;
  logic                  r_mdu_abort;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  w_hz;
  logic                  w_md;
  logic                  w_div;
  logic                  w_busy;
  hazard_cmp #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard_cmp (
    .valid_p23   (valid_p23),
    .valid_p34   (valid_p34),
    .load_p34    (load_p34),
    .use_A       (use_A),
    .use_B       (use_B),
    .A_addr      (A_addr),
    .B_addr      (B_addr),
    .reg_addr_p34(reg_addr_p34),
    .hz          (w_hz)
  );
  assign w_div  = valid_p23 & (ctrl_p23 == CTRL_WIDTH'(params_proc::OP_DIV));
  assign w_md   = w_div | (valid_p23 & (ctrl_p23 == CTRL_WIDTH'(params_proc::OP_MUL)));
  // MDU result lands in its final cycle, when cnt has reached zero
  assign w_busy = (r_state == MDU) & (r_cnt != '0);
  always_comb begin
    bubble_p3 = (r_state == LSTALL) | ((r_state == IDLE) & w_hz);
    hold_p12  = bubble_p3 | w_busy;
    done_p3   = !w_busy;
  end
  always_ff @(posedge clk_p3 or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mdu_start <= 1'b0;
      r_mdu_op    <= 1'b0;
      r_mdu_abort <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_mdu_start <= 1'b0;
      r_mdu_abort <= 1'b0;
      if (hold_p12 && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (flush) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_mdu_abort <= (r_state == MDU);
      end else if (r_state == IDLE) begin
        if (w_hz) begin
          if (LU_STALL > 1) begin
            r_state <= LSTALL;
            r_cnt   <= CW'(LU_STALL - 2);
          end
        end else if (w_md) begin
          r_state     <= MDU;
          r_cnt       <= w_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          r_mdu_op    <= w_div;
          r_mdu_start <= 1'b1;
        end
      end else if (r_cnt == '0) begin
        r_state <= IDLE;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
  assign mdu_start = r_mdu_start;
  assign mdu_op    = r_mdu_op;
  assign mdu_abort = r_mdu_abort;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_exec_hazard_sched.sv
// tb_exec_hazard_sched: directed checks of load-use stalls, MDU sequencing, flush and reset.
module tb_exec_hazard_sched;
  logic        clk_p3 = 1'b0;
  logic        RST = 1'b0;
  logic        valid_p23 = 1'b0;
  logic [5:0]  ctrl_p23 = 6'h00;
  logic [3:0]  A_addr = 4'd0;
  logic [3:0]  B_addr = 4'd0;
  logic        use_A = 1'b0;
  logic        use_B = 1'b0;
  logic        valid_p34 = 1'b0;
  logic        load_p34 = 1'b0;
  logic [3:0]  reg_addr_p34 = 4'd0;
  logic        flush = 1'b0;
  logic        hold_p12, bubble_p3, done_p3, mdu_start, mdu_op, mdu_abort;
  logic [15:0] stall_cnt;
  int          errs = 0;
  int          checks = 0;
  int          exp_sc = 0;
  localparam logic [5:0] LW = 6'h03, MUL = 6'h18, DIV = 6'h1a;

  exec_hazard_sched dut (
    .clk_p3(clk_p3), .RST(RST), .valid_p23(valid_p23), .ctrl_p23(ctrl_p23),
    .A_addr(A_addr), .B_addr(B_addr), .use_A(use_A), .use_B(use_B),
    .valid_p34(valid_p34), .load_p34(load_p34), .reg_addr_p34(reg_addr_p34),
    .flush(flush), .hold_p12(hold_p12), .bubble_p3(bubble_p3), .done_p3(done_p3),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_abort(mdu_abort), .stall_cnt(stall_cnt)
  );

  always #5 clk_p3 = ~clk_p3;

  task automatic nxt();
    @(posedge clk_p3);
    #2;
  endtask

  task automatic clr_in();
    valid_p23 = 0; ctrl_p23 = 0; A_addr = 0; B_addr = 0; use_A = 0; use_B = 0;
    valid_p34 = 0; load_p34 = 0; reg_addr_p34 = 0; flush = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (mdu_start !== 1'b0) begin errs++; $display("FAIL rst_start got %0b want 0", mdu_start); end
    checks++; if (mdu_op !== 1'b0) begin errs++; $display("FAIL rst_op got %0b want 0", mdu_op); end
    checks++; if (mdu_abort !== 1'b0) begin errs++; $display("FAIL rst_abort got %0b want 0", mdu_abort); end
    checks++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL rst_hold got %0b want 0", hold_p12); end
    checks++; if (bubble_p3 !== 1'b0) begin errs++; $display("FAIL rst_bubble got %0b want 0", bubble_p3); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL rst_done got %0b want 1", done_p3); end
    RST = 1;
    nxt();
    valid_p23 = 1; ctrl_p23 = LW;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL idle_op_hold got %0b want 0", hold_p12); end
    nxt();
    checks++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL idle_op_stall_cnt got %0d want 0", stall_cnt); end
    checks++; if (mdu_start !== 1'b0) begin errs++; $display("FAIL idle_op_start got %0b want 0", mdu_start); end
    clr_in();
  endtask

  task automatic test_load_use();
    valid_p23 = 1; ctrl_p23 = LW; A_addr = 5; use_A = 1;
    valid_p34 = 1; load_p34 = 1; reg_addr_p34 = 5;
    #1;
    checks++; if (hold_p12 !== 1'b1) begin errs++; $display("FAIL lu_hold got %0b want 1", hold_p12); end
    checks++; if (bubble_p3 !== 1'b1) begin errs++; $display("FAIL lu_bubble got %0b want 1", bubble_p3); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL lu_done got %0b want 1", done_p3); end
    nxt();
    exp_sc += 1;
    valid_p34 = 0; load_p34 = 0;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL lu_after_hold got %0b want 0", hold_p12); end
    checks++; if (bubble_p3 !== 1'b0) begin errs++; $display("FAIL lu_after_bubble got %0b want 0", bubble_p3); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errs++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, exp_sc); end
    clr_in();
  endtask

  task automatic test_no_hazard();
    valid_p23 = 1; ctrl_p23 = LW; A_addr = 0; use_A = 1;
    valid_p34 = 1; load_p34 = 1; reg_addr_p34 = 0;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL zero_reg_hold got %0b want 0", hold_p12); end
    nxt();
    use_A = 0; A_addr = 3; B_addr = 7; use_B = 0; reg_addr_p34 = 7;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL unused_b_hold got %0b want 0", hold_p12); end
    nxt();
    use_B = 1; load_p34 = 0;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL non_load_hold got %0b want 0", hold_p12); end
    nxt();
    load_p34 = 1;
    #1;
    checks++; if (bubble_p3 !== 1'b1) begin errs++; $display("FAIL b_match_bubble got %0b want 1", bubble_p3); end
    nxt();
    exp_sc += 1;
    clr_in();
    #1;
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errs++; $display("FAIL nohz_stall_cnt got %0d want %0d", stall_cnt, exp_sc); end
  endtask

  task automatic run_mdu(input logic [5:0] op, input int lat, input string nm);
    valid_p23 = 1; ctrl_p23 = op;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL %s_launch_hold got %0b want 0", nm, hold_p12); end
    nxt();
    for (int i = 1; i <= lat; i++) begin
      #1;
      checks++; if (mdu_start !== (i == 1)) begin errs++; $display("FAIL %s_start c%0d got %0b want %0b", nm, i, mdu_start, i == 1); end
      checks++; if (mdu_op !== (op == DIV)) begin errs++; $display("FAIL %s_op c%0d got %0b want %0b", nm, i, mdu_op, op == DIV); end
      checks++; if (hold_p12 !== (i < lat)) begin errs++; $display("FAIL %s_hold c%0d got %0b want %0b", nm, i, hold_p12, i < lat); end
      checks++; if (done_p3 !== (i == lat)) begin errs++; $display("FAIL %s_done c%0d got %0b want %0b", nm, i, done_p3, i == lat); end
      nxt();
    end
    exp_sc += lat - 1;
    valid_p23 = 0;
    #1;
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errs++; $display("FAIL %s_stall_cnt got %0d want %0d", nm, stall_cnt, exp_sc); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL %s_idle_done got %0b want 1", nm, done_p3); end
    clr_in();
  endtask

  task automatic test_back_to_back();
    valid_p23 = 1; ctrl_p23 = MUL;
    nxt();
    for (int i = 1; i <= 4; i++) nxt();
    ctrl_p23 = DIV;
    #1;
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL b2b_idle_hold got %0b want 0", hold_p12); end
    nxt();
    #1;
    checks++; if (mdu_start !== 1'b1) begin errs++; $display("FAIL b2b_start got %0b want 1", mdu_start); end
    checks++; if (mdu_op !== 1'b1) begin errs++; $display("FAIL b2b_op got %0b want 1", mdu_op); end
    nxt();
    flush = 1; valid_p23 = 0;
    #1;
    checks++; if (hold_p12 !== 1'b1) begin errs++; $display("FAIL flush_cycle_hold got %0b want 1", hold_p12); end
    checks++; if (done_p3 !== 1'b0) begin errs++; $display("FAIL flush_cycle_done got %0b want 0", done_p3); end
    checks++; if (mdu_abort !== 1'b0) begin errs++; $display("FAIL flush_cycle_abort got %0b want 0", mdu_abort); end
    nxt();
    flush = 0;
    exp_sc += 3 + 2;
    #1;
    checks++; if (mdu_abort !== 1'b1) begin errs++; $display("FAIL flush_abort got %0b want 1", mdu_abort); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL flush_done got %0b want 1", done_p3); end
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL flush_hold got %0b want 0", hold_p12); end
    checks++; if (mdu_start !== 1'b0) begin errs++; $display("FAIL flush_start got %0b want 0", mdu_start); end
    nxt();
    #1;
    checks++; if (mdu_abort !== 1'b0) begin errs++; $display("FAIL flush_abort_once got %0b want 0", mdu_abort); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL flush_done_after got %0b want 1", done_p3); end
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errs++; $display("FAIL flush_stall_cnt got %0d want %0d", stall_cnt, exp_sc); end
    clr_in();
  endtask

  task automatic test_hz_md();
    valid_p23 = 1; ctrl_p23 = MUL; A_addr = 9; use_A = 1;
    valid_p34 = 1; load_p34 = 1; reg_addr_p34 = 9;
    #1;
    checks++; if (bubble_p3 !== 1'b1) begin errs++; $display("FAIL hzmd_bubble got %0b want 1", bubble_p3); end
    checks++; if (hold_p12 !== 1'b1) begin errs++; $display("FAIL hzmd_hold got %0b want 1", hold_p12); end
    nxt();
    valid_p34 = 0; load_p34 = 0;
    #1;
    checks++; if (mdu_start !== 1'b0) begin errs++; $display("FAIL hzmd_no_early_start got %0b want 0", mdu_start); end
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL hzmd_relaunch_hold got %0b want 0", hold_p12); end
    nxt();
    #1;
    checks++; if (mdu_start !== 1'b1) begin errs++; $display("FAIL hzmd_start got %0b want 1", mdu_start); end
    for (int i = 1; i <= 4; i++) nxt();
    valid_p23 = 0;
    exp_sc += 1 + 3;
    #1;
    checks++; if (stall_cnt !== 16'(exp_sc)) begin errs++; $display("FAIL hzmd_stall_cnt got %0d want %0d", stall_cnt, exp_sc); end
    clr_in();
  endtask

  task automatic test_rst_mid();
    valid_p23 = 1; ctrl_p23 = DIV;
    nxt();
    nxt();
    RST = 0;
    #1;
    checks++; if (mdu_op !== 1'b0) begin errs++; $display("FAIL rstmid_op got %0b want 0", mdu_op); end
    checks++; if (hold_p12 !== 1'b0) begin errs++; $display("FAIL rstmid_hold got %0b want 0", hold_p12); end
    checks++; if (done_p3 !== 1'b1) begin errs++; $display("FAIL rstmid_done got %0b want 1", done_p3); end
    checks++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rstmid_stall_cnt got %0d want 0", stall_cnt); end
    clr_in();
    nxt();
    RST = 1;
    nxt();
    #1;
    checks++; if (mdu_abort !== 1'b0) begin errs++; $display("FAIL rstmid_abort got %0b want 0", mdu_abort); end
    checks++; if (mdu_start !== 1'b0) begin errs++; $display("FAIL rstmid_start got %0b want 0", mdu_start); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    run_mdu(MUL, 4, "mul");
    run_mdu(DIV, 16, "div");
    test_back_to_back();
    test_hz_md();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
